// File: rtl/apb_master_ctrl.sv
// Command-to-APB3 bridge: one transfer per command; rsp 3 cycles after accept (+1 per wait, 1 on decode miss).
// Backpressure: cmd_ready only in IDLE; a held-off response parks the bridge in RESP with stable data.
package apb_pkg;
    localparam logic [31:0] SLAVE_ADDR = 32'hA000;
endpackage

module apb_master_ctrl #(
    parameter logic [31:0] BASE_ADDR = apb_pkg::SLAVE_ADDR,
    parameter logic [31:0] ADDR_MASK = 32'hFFFF_F000,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic        pclk,
    input  logic        presetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  wait_cnt;
    logic [7:0]  wait_cnt_nxt;
    logic [31:0] rdata_nxt;
    logic        err_nxt;
    logic        accept;
    logic        addr_hit;

    assign accept   = cmd_valid && (state == IDLE);
    assign addr_hit = (cmd_addr & ADDR_MASK) == (BASE_ADDR & ADDR_MASK);

    // Controls decode straight from state so an async reset clears them at once.
    assign cmd_ready = (state == IDLE);
    assign psel      = (state == SETUP) || (state == ACCESS);
    assign penable   = (state == ACCESS);
    assign rsp_valid = (state == RESP);

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        rdata_nxt    = rsp_rdata;
        err_nxt      = rsp_err;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (addr_hit) begin
                        state_nxt    = SETUP;
                        wait_cnt_nxt = 8'd0;
                    end else begin
                        state_nxt = RESP;
                        rdata_nxt = 32'd0;
                        err_nxt   = 1'b1;
                    end
                end
            end
            SETUP: begin
                state_nxt = ACCESS;
            end
            ACCESS: begin
                // Completion wins over timeout when pready arrives on the last allowed cycle.
                if (pready) begin
                    state_nxt = RESP;
                    rdata_nxt = pwrite ? 32'd0 : prdata;
                    err_nxt   = 1'b0;
                end else begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                    if (wait_cnt + 8'd1 == TIMEOUT_LIM) begin
                        state_nxt = RESP;
                        rdata_nxt = 32'd0;
                        err_nxt   = 1'b1;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state     <= IDLE;
            wait_cnt  <= 8'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            rsp_rdata <= rdata_nxt;
            rsp_err   <= err_nxt;
        end
    end

    // Command fields are captured at accept and held until the next accept.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            paddr  <= 32'd0;
            pwdata <= 32'd0;
            pwrite <= 1'b0;
        end else if (accept) begin
            paddr  <= cmd_addr;
            pwdata <= cmd_wdata;
            pwrite <= cmd_write;
        end
    end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Bench for apb_master_ctrl: directed vector table, hand sequences and randomized commands vs a reference model.
module tb_apb_master_ctrl;

    localparam int          TO   = 4;
    localparam logic [31:0] BASE = 32'hA000;
    localparam logic [31:0] MASK = 32'hFFFF_F000;

    logic        pclk = 1'b0;
    logic        presetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;

    int          n_checks = 0;
    int          n_errors = 0;

    int          slave_waits = 0;
    logic [31:0] slave_rdata = 32'd0;
    int          acc_cnt;

    apb_master_ctrl #(
        .BASE_ADDR (BASE),
        .ADDR_MASK (MASK),
        .TIMEOUT   (TO)
    ) dut (
        .pclk      (pclk),
        .presetn   (presetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready)
    );

    always #5 pclk = ~pclk;

    // Slave: raises pready on the ACCESS cycle after slave_waits wait cycles.
    always @(posedge pclk or negedge presetn) begin
        if (!presetn)            acc_cnt <= 0;
        else if (psel && penable) acc_cnt <= acc_cnt + 1;
        else                     acc_cnt <= 0;
    end
    assign pready = psel && penable && (acc_cnt == slave_waits);
    assign prdata = pready ? slave_rdata : 32'hBAD0_BAD0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: outcome of one command derived from the window and wait rules.
    function automatic void model(input logic wr, input logic [31:0] addr, input int waits,
                                  input logic [31:0] sdata, output int lat, output logic err,
                                  output logic [31:0] rd, output int nsel, output int nen);
        if ((addr & MASK) != (BASE & MASK)) begin
            lat = 1; err = 1'b1; rd = 32'd0; nsel = 0; nen = 0;
        end else if (waits < TO) begin
            nen = waits + 1; nsel = nen + 1; lat = nsel + 1;
            err = 1'b0; rd = wr ? 32'd0 : sdata;
        end else begin
            nen = TO; nsel = TO + 1; lat = TO + 2; err = 1'b1; rd = 32'd0;
        end
    endfunction

    task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int waits, input logic [31:0] sdata, input int hold,
                           output int lat, output logic err, output logic [31:0] rd,
                           output int nsel, output int nen, output logic ok);
        int guard;
        @(negedge pclk);
        slave_waits = waits;
        slave_rdata = sdata;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
        rsp_ready = 1'b0;
        guard = 0;
        while (!cmd_ready && guard < 50) begin
            @(negedge pclk);
            guard++;
        end
        @(negedge pclk);
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = 32'($urandom);
        cmd_wdata = 32'($urandom);
        lat = 1; nsel = 0; nen = 0; ok = 1'b1;
        while (!rsp_valid && lat < 300) begin
            if (psel) begin
                nsel++;
                if (paddr !== addr || pwrite !== wr || pwdata !== wdata) ok = 1'b0;
                if (nsel == 1 && penable) ok = 1'b0;
            end
            if (penable) begin
                nen++;
                if (!psel) ok = 1'b0;
            end
            @(negedge pclk);
            lat++;
        end
        err = rsp_err;
        rd  = rsp_rdata;
        if (psel || penable || cmd_ready) ok = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(negedge pclk);
            if (!rsp_valid || rsp_err !== err || rsp_rdata !== rd || cmd_ready || psel) ok = 1'b0;
        end
        rsp_ready = 1'b1;
        @(negedge pclk);
        rsp_ready = 1'b0;
        if (rsp_valid || !cmd_ready) ok = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] sdata;
        int          exp_lat;
        logic        exp_err;
        logic [31:0] exp_rd;
        int          exp_sel;
        int          exp_en;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int          lat, nsel, nen;
        logic        err, ok;
        logic [31:0] rd;
        int          m_lat, m_sel, m_en;
        logic        m_err;
        logic [31:0] m_rd;
        logic        r_wr;
        logic [31:0] r_addr, r_wdata, r_sdata;
        int          r_waits, r_hold;
        logic        stable;

        vecs[0] = '{1'b1, 32'h0000_A004, 32'hDEAD_BEEF, 0,   32'h0,         3, 1'b0, 32'h0,         2, 1};
        vecs[1] = '{1'b0, 32'h0000_A010, 32'h0,         3,   32'h1234_5678, 6, 1'b0, 32'h1234_5678, 5, 4};
        vecs[2] = '{1'b0, 32'h0000_B000, 32'h0,         0,   32'h5A5A_5A5A, 1, 1'b1, 32'h0,         0, 0};
        vecs[3] = '{1'b0, 32'h0000_A020, 32'h0,         100, 32'h7777_7777, 6, 1'b1, 32'h0,         5, 4};
        vecs[4] = '{1'b1, 32'h0000_A0FC, 32'h0BAD_CAFE, 3,   32'h1111_1111, 6, 1'b0, 32'h0,         5, 4};
        vecs[5] = '{1'b0, 32'h0000_AFFC, 32'h0,         1,   32'hCAFE_F00D, 4, 1'b0, 32'hCAFE_F00D, 3, 2};
        vecs[6] = '{1'b1, 32'h0001_A000, 32'h1357_9BDF, 0,   32'h0,         1, 1'b1, 32'h0,         0, 0};
        vecs[7] = '{1'b0, 32'h0000_A008, 32'h0,         4,   32'h2222_2222, 6, 1'b1, 32'h0,         5, 4};

        presetn = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'd0; cmd_wdata = 32'd0;
        rsp_ready = 1'b0;
        #1;
        chk("reset psel",      {31'd0, psel},      32'd0);
        chk("reset penable",   {31'd0, penable},   32'd0);
        chk("reset pwrite",    {31'd0, pwrite},    32'd0);
        chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset rsp_err",   {31'd0, rsp_err},   32'd0);
        chk("reset cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("reset paddr",     paddr,              32'd0);
        chk("reset pwdata",    pwdata,             32'd0);
        chk("reset rsp_rdata", rsp_rdata,          32'd0);
        repeat (3) @(negedge pclk);
        presetn = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].waits, vecs[i].sdata, i % 3,
                    lat, err, rd, nsel, nen, ok);
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("vec%0d rsp_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
            chk($sformatf("vec%0d rsp_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d psel cycles", i), 32'(nsel), 32'(vecs[i].exp_sel));
            chk($sformatf("vec%0d penable cycles", i), 32'(nen), 32'(vecs[i].exp_en));
            chk($sformatf("vec%0d protocol", i), {31'd0, ok}, 32'd1);
        end

        // Back-pressure for 5 cycles with a second command queued behind the response.
        @(negedge pclk);
        slave_waits = 0; slave_rdata = 32'h5555_AAAA;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_A040; cmd_wdata = 32'd0;
        rsp_ready = 1'b0;
        @(negedge pclk);
        cmd_write = 1'b1; cmd_addr = 32'h0000_A044; cmd_wdata = 32'h0F0F_0F0F;
        @(negedge pclk);
        @(negedge pclk);
        chk("bp rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("bp rsp_rdata", rsp_rdata, 32'h5555_AAAA);
        stable = 1'b1;
        for (int h = 0; h < 5; h++) begin
            if (!rsp_valid || rsp_rdata !== 32'h5555_AAAA || rsp_err || cmd_ready) stable = 1'b0;
            if (h < 4) @(negedge pclk);
        end
        chk("bp stable", {31'd0, stable}, 32'd1);
        rsp_ready = 1'b1;
        @(negedge pclk);
        rsp_ready = 1'b0;
        chk("bp cmd_ready after handshake", {31'd0, cmd_ready}, 32'd1);
        chk("bp rsp_valid after handshake", {31'd0, rsp_valid}, 32'd0);
        @(negedge pclk);
        cmd_valid = 1'b0;
        chk("b2b setup psel",   {31'd0, psel},    32'd1);
        chk("b2b setup penable", {31'd0, penable}, 32'd0);
        chk("b2b paddr",        paddr,            32'h0000_A044);
        chk("b2b pwrite",       {31'd0, pwrite},  32'd1);
        @(negedge pclk);
        @(negedge pclk);
        chk("b2b rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("b2b rsp_err",   {31'd0, rsp_err},   32'd0);
        chk("b2b rsp_rdata", rsp_rdata,          32'd0);
        rsp_ready = 1'b1;
        @(negedge pclk);
        rsp_ready = 1'b0;

        // Asynchronous reset in the middle of ACCESS.
        slave_waits = 10;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_A100;
        @(negedge pclk);
        cmd_valid = 1'b0;
        @(negedge pclk);
        chk("rst pre penable", {31'd0, penable}, 32'd1);
        #2 presetn = 1'b0;
        #1;
        chk("rst psel",      {31'd0, psel},      32'd0);
        chk("rst penable",   {31'd0, penable},   32'd0);
        chk("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst cmd_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge pclk);
        presetn = 1'b1;
        @(negedge pclk);
        chk("rst no response", {31'd0, rsp_valid}, 32'd0);
        run_cmd(1'b0, 32'h0000_A104, 32'd0, 1, 32'h0A0B_0C0D, 0, lat, err, rd, nsel, nen, ok);
        chk("post-rst latency", 32'(lat), 32'd4);
        chk("post-rst rsp_err", {31'd0, err}, 32'd0);
        chk("post-rst rsp_rdata", rd, 32'h0A0B_0C0D);
        chk("post-rst protocol", {31'd0, ok}, 32'd1);

        for (int i = 0; i < 40; i++) begin
            r_wr    = 1'($urandom_range(0, 1));
            r_addr  = ($urandom_range(0, 3) != 0) ? {20'h0000A, 12'($urandom)} : 32'($urandom);
            r_wdata = 32'($urandom);
            r_sdata = 32'($urandom);
            r_waits = int'($urandom_range(0, 6));
            r_hold  = int'($urandom_range(0, 3));
            model(r_wr, r_addr, r_waits, r_sdata, m_lat, m_err, m_rd, m_sel, m_en);
            run_cmd(r_wr, r_addr, r_wdata, r_waits, r_sdata, r_hold, lat, err, rd, nsel, nen, ok);
            chk($sformatf("rnd%0d latency", i), 32'(lat), 32'(m_lat));
            chk($sformatf("rnd%0d rsp_err", i), {31'd0, err}, {31'd0, m_err});
            chk($sformatf("rnd%0d rsp_rdata", i), rd, m_rd);
            chk($sformatf("rnd%0d psel cycles", i), 32'(nsel), 32'(m_sel));
            chk($sformatf("rnd%0d penable cycles", i), 32'(nen), 32'(m_en));
            chk($sformatf("rnd%0d protocol", i), {31'd0, ok}, 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
